// File: rtl/uart_channel_scheduler_pkg.sv
// Shared types and constants for the three-channel UART scheduler.
package uart_channel_scheduler_pkg;

  localparam int unsigned CH_COUNT        = 3;
  localparam int unsigned GAP_DEFAULT     = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 200000;
  localparam int unsigned CNT_W           = 18;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StGap      = 3'd4
  } state_e;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;

  // Successor channel in round-robin order, wrapping ch2 back to ch0.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == SEL_CH2) ? SEL_CH0 : ch + 2'd1;
  endfunction

  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    logic [2:0] oh;
    oh = 3'b000;
    case (ch)
      SEL_CH1: oh = 3'b010;
      SEL_CH2: oh = 3'b100;
      default: oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/uart_channel_scheduler_rr_picker.sv
// Combinational round-robin picker: first requesting channel at or after ptr.
module uart_channel_scheduler_rr_picker
  import uart_channel_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = SEL_CH0;
    case (ptr)
      SEL_CH1: grant = req[1] ? SEL_CH1 : (req[2] ? SEL_CH2 : SEL_CH0);
      SEL_CH2: grant = req[2] ? SEL_CH2 : (req[0] ? SEL_CH0 : SEL_CH1);
      default: grant = req[0] ? SEL_CH0 : (req[1] ? SEL_CH1 : SEL_CH2);
    endcase
  end

endmodule

// File: rtl/uart_channel_scheduler.sv
// Round-robin scheduler sharing one UART transceiver between three channels,
// with frame timeout and an inter-frame guard gap.
module uart_channel_scheduler
  import uart_channel_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH         = CH_COUNT,
  parameter int unsigned GAP_CYCLES     = GAP_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   req,
  input  logic [8*NUM_CH-1:0] req_data,
  output logic [NUM_CH-1:0]   ack,
  output logic [NUM_CH-1:0]   err,
  output logic [1:0]          sel,
  output logic                uart_tx_start,
  output logic [7:0]          uart_data,
  input  logic                uart_tx_busy,
  output logic                busy
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] pick_grant;
  logic       pick_valid;
  logic [7:0] pick_byte;
  logic       timeout;

  uart_channel_scheduler_rr_picker u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    pick_byte = req_data[7:0];
    case (pick_grant)
      SEL_CH1: pick_byte = req_data[15:8];
      SEL_CH2: pick_byte = req_data[23:16];
      default: pick_byte = req_data[7:0];
    endcase
  end

  assign timeout = (cnt_q >= TO_LAST);

  // One counter serves both the frame timeout and the guard gap; it is
  // cleared on entry to each phase and saturates instead of wrapping.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    sel_d         = sel_q;
    data_d        = data_q;
    cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    uart_tx_start = 1'b0;
    ack           = '0;
    err           = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d   = pick_grant;
          data_d  = pick_byte;
          state_d = StStart;
        end
      end
      StStart: begin
        uart_tx_start = 1'b1;
        cnt_d         = '0;
        state_d       = StWaitBusy;
      end
      StWaitBusy: begin
        if (uart_tx_busy) begin
          state_d = StWaitDone;
        end else if (timeout) begin
          err      = ch_onehot(sel_q);
          rr_ptr_d = next_ch(sel_q);
          cnt_d    = '0;
          state_d  = StGap;
        end
      end
      StWaitDone: begin
        // Completion wins over a timeout landing in the same cycle.
        if (!uart_tx_busy) begin
          ack      = ch_onehot(sel_q);
          rr_ptr_d = next_ch(sel_q);
          cnt_d    = '0;
          state_d  = StGap;
        end else if (timeout) begin
          err      = ch_onehot(sel_q);
          rr_ptr_d = next_ch(sel_q);
          cnt_d    = '0;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= SEL_CH0;
      sel_q    <= SEL_CH0;
      data_q   <= 8'h00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign uart_data = data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_channel_scheduler.sv
// Self-checking bench: frame-level reference model predicts grant, byte and
// completion cycle for each frame from the request, pointer and busy profile.
module tb_uart_channel_scheduler;

  localparam int unsigned T = 50;
  localparam int unsigned G = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [1:0]  sel;
  logic        uart_tx_start;
  logic [7:0]  uart_data;
  logic        uart_tx_busy;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int         m_ptr  = 0;
  logic [1:0] m_sel  = 2'b00;
  logic [7:0] m_data = 8'h00;

  uart_channel_scheduler #(
    .NUM_CH         (3),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .err           (err),
    .sel           (sel),
    .uart_tx_start (uart_tx_start),
    .uart_data     (uart_data),
    .uart_tx_busy  (uart_tx_busy),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [17:0] pack(input logic b, input logic s, input logic [1:0] sl,
                                       input logic [7:0] d, input logic [2:0] a,
                                       input logic [2:0] e);
    return {b, s, sl, d, a, e};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] got;
    got = pack(busy, uart_tx_start, sel, uart_data, ack, err);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed busy=%0b start=%0b sel=%0d data=%02h ack=%03b err=%03b, expected busy=%0b start=%0b sel=%0d data=%02h ack=%03b err=%03b",
             tag, got[17], got[16], got[15:14], got[13:6], got[5:3], got[2:0],
             exp[17], exp[16], exp[15:14], exp[13:6], exp[5:3], exp[2:0]);
    end
  endtask

  // First requesting channel at or after ptr, wrapping.
  function automatic int pick(input logic [2:0] r, input int ptr);
    for (int i = 0; i < 3; i++) begin
      int c;
      c = (ptr + i) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic idle_cycles(input int n);
    req = 3'b000;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; uart_tx_busy = 1'b0; #1;
      check("idle", pack(1'b0, 1'b0, m_sel, m_data, 3'b000, 3'b000));
    end
  endtask

  // Caller is in an idle cycle. Busy is high for cycles rise..rise+len-1
  // after the strobe (rise = 0 means never); r_mid replaces req after grant.
  task automatic run_frame(input string tag, input logic [2:0] r, input logic [23:0] bytes,
                           input int rise, input int len, input logic [2:0] r_mid);
    int         g;
    int         e_cyc;
    bit         is_ack;
    logic [7:0] b;
    logic [2:0] oh;
    g = pick(r, m_ptr);
    b = bytes[g*8 +: 8];
    oh = 3'b001 << g;
    if (rise > 0 && rise < int'(T) && rise + len <= int'(T)) begin
      is_ack = 1'b1;
      e_cyc  = rise + len;
    end else begin
      is_ack = 1'b0;
      e_cyc  = T;
    end
    req = r;
    req_data = bytes;
    @(posedge clk); #1;
    uart_tx_busy = 1'b0;
    req = r_mid;
    #1;
    check({tag, "/strobe"}, pack(1'b1, 1'b1, 2'(g), b, 3'b000, 3'b000));
    for (int k = 1; k <= e_cyc + int'(G) + 1; k++) begin
      @(posedge clk); #1;
      uart_tx_busy = (rise > 0 && k >= rise && k < rise + len);
      #1;
      check(tag, pack(k <= e_cyc + int'(G), 1'b0, 2'(g), b,
                      (k == e_cyc && is_ack) ? oh : 3'b000,
                      (k == e_cyc && !is_ack) ? oh : 3'b000));
    end
    m_ptr  = (g + 1) % 3;
    m_sel  = 2'(g);
    m_data = b;
  endtask

  task automatic apply_reset();
    req = 3'b000;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_async", pack(1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 3'b000));
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0; m_sel = 2'b00; m_data = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b111;
    req_data = 24'h332211;
    uart_tx_busy = 1'b0;
    @(posedge clk); #2;
    check("reset_state", pack(1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 3'b000));
    @(posedge clk); #2;
    check("reset_held", pack(1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 3'b000));
    reset = 1'b0;
    idle_cycles(2);

    run_frame("single", 3'b001, 24'h0000A5, 2, 20, 3'b001);
    idle_cycles(1);

    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_frame("all_three", 3'b111, 24'h332211, 1, 3 + i, 3'b111);
    end

    run_frame("fair_ch1", 3'b010, 24'h00BB00, 2, 4, 3'b010);
    run_frame("fair_wrap", 3'b011, 24'h00CCDD, 2, 4, 3'b011);

    run_frame("timeout", 3'b100, 24'h5A0000, 0, 0, 3'b100);
    run_frame("req_drop", 3'b010, 24'h003C00, 2, 10, 3'b000);
    idle_cycles(1);

    // Reset during WAIT_DONE: m_ptr is now 2, so this grants ch1.
    req = 3'b010;
    req_data = 24'h00E700;
    @(posedge clk); #1; uart_tx_busy = 1'b0; #1;
    check("midrst/strobe", pack(1'b1, 1'b1, 2'b01, 8'hE7, 3'b000, 3'b000));
    @(posedge clk); #1; uart_tx_busy = 1'b1; #1;
    check("midrst/wait_busy", pack(1'b1, 1'b0, 2'b01, 8'hE7, 3'b000, 3'b000));
    @(posedge clk); #1; uart_tx_busy = 1'b1; #1;
    check("midrst/wait_done", pack(1'b1, 1'b0, 2'b01, 8'hE7, 3'b000, 3'b000));
    @(posedge clk); #1;
    uart_tx_busy = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst/abort", pack(1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 3'b000));
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0; m_sel = 2'b00; m_data = 8'h00;
    #1;
    check("midrst/released", pack(1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 3'b000));
    run_frame("post_reset", 3'b111, 24'h778899, 1, 5, 3'b111);

    for (int n = 0; n < 30; n++) begin
      logic [2:0]  r;
      logic [2:0]  rm;
      logic [23:0] bytes;
      int          rise;
      int          len;
      r     = 3'($urandom_range(1, 7));
      rm    = 3'($urandom_range(0, 7));
      bytes = 24'($urandom);
      rise  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      len   = int'($urandom_range(1, 60));
      run_frame("random", r, bytes, rise, len, rm);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
